// File: rtl/ex_stage.sv
// Execute stage: single-cycle ALU ops plus a WIDTH-cycle shift-add multiplier behind a
// valid/ready handshake. Optional result forwarding is built when EX_STAGE_FWD_EN is defined.
module ex_stage #(
  parameter int unsigned WIDTH = 16
) (
  input  logic             clock,
  input  logic             reset_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [1:0]       RR1,
  input  logic [1:0]       RR2,
  input  logic [WIDTH-1:0] A,
  input  logic [WIDTH-1:0] B,
  input  logic [2:0]       ALUctl,
  input  logic [1:0]       WR_in,
  input  logic             RegWrite_in,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] Result,
  output logic             Zero,
  output logic [1:0]       WR,
  output logic             RegWrite
);

  localparam logic [1:0] IDLE = 2'd0;
  localparam logic [1:0] MUL  = 2'd1;
  localparam logic [1:0] HOLD = 2'd2;

  localparam logic [2:0] OP_AND = 3'b000;
  localparam logic [2:0] OP_OR  = 3'b001;
  localparam logic [2:0] OP_ADD = 3'b010;
  localparam logic [2:0] OP_MUL = 3'b011;
  localparam logic [2:0] OP_SUB = 3'b110;
  localparam logic [2:0] OP_SLT = 3'b111;

  localparam int unsigned CW = (WIDTH > 1) ? $clog2(WIDTH) : 1;
  localparam logic [CW-1:0] LAST = CW'(WIDTH - 1);

  logic [1:0]       state_q, state_d;
  logic [WIDTH-1:0] result_q, result_d;
  logic [1:0]       wr_q, wr_d;
  logic             rw_q, rw_d;
  logic [WIDTH-1:0] mcand_q, mcand_d;
  logic [WIDTH-1:0] mplier_q, mplier_d;
  logic [WIDTH-1:0] acc_q, acc_d;
  logic [CW-1:0]    cnt_q, cnt_d;

  logic             accept;
  logic             mul_done;
  logic [WIDTH-1:0] a_op, b_op;
  logic [WIDTH-1:0] alu_res;
  logic [WIDTH-1:0] acc_step;

`ifdef EX_STAGE_FWD_EN
  logic             fwd_valid_q;
  logic [1:0]       fwd_idx_q;
  logic [WIDTH-1:0] fwd_val_q;
  logic             complete;
`else
  logic             unused_rr;
  assign unused_rr = ^{RR1, RR2};
`endif

  always_comb begin
    a_op = A;
    b_op = B;
`ifdef EX_STAGE_FWD_EN
    // Index 0 is never recorded, so it can never forward.
    if (fwd_valid_q && (fwd_idx_q == RR1)) a_op = fwd_val_q;
    if (fwd_valid_q && (fwd_idx_q == RR2)) b_op = fwd_val_q;
`endif
  end

  always_comb begin
    alu_res = '0;
    case (ALUctl)
      OP_AND:  alu_res = a_op & b_op;
      OP_OR:   alu_res = a_op | b_op;
      OP_ADD:  alu_res = a_op + b_op;
      OP_SUB:  alu_res = a_op - b_op;
      OP_SLT:  alu_res = {{(WIDTH-1){1'b0}}, ($signed(a_op) < $signed(b_op))};
      default: alu_res = '0;
    endcase
  end

  assign in_ready = (state_q != MUL) && ((state_q != HOLD) || out_ready);
  assign accept   = in_valid && in_ready;
  assign acc_step = acc_q + (mplier_q[0] ? mcand_q : '0);
  assign mul_done = (state_q == MUL) && (cnt_q == LAST);

  always_comb begin
    state_d  = state_q;
    result_d = result_q;
    wr_d     = wr_q;
    rw_d     = rw_q;
    mcand_d  = mcand_q;
    mplier_d = mplier_q;
    acc_d    = acc_q;
    cnt_d    = cnt_q;
    case (state_q)
      MUL: begin
        acc_d    = acc_step;
        mcand_d  = mcand_q << 1;
        mplier_d = mplier_q >> 1;
        cnt_d    = cnt_q + 1'b1;
        if (mul_done) begin
          state_d  = HOLD;
          result_d = acc_step;
        end
      end
      default: begin
        if (accept) begin
          wr_d = WR_in;
          rw_d = RegWrite_in;
          if (ALUctl == OP_MUL) begin
            state_d  = MUL;
            mcand_d  = a_op;
            mplier_d = b_op;
            acc_d    = '0;
            cnt_d    = '0;
          end else begin
            state_d  = HOLD;
            result_d = alu_res;
          end
        end else if ((state_q != HOLD) || out_ready) begin
          // Also pulls the unused encoding back to IDLE.
          state_d = IDLE;
        end
      end
    endcase
  end

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      state_q  <= IDLE;
      result_q <= '0;
      wr_q     <= '0;
      rw_q     <= 1'b0;
      mcand_q  <= '0;
      mplier_q <= '0;
      acc_q    <= '0;
      cnt_q    <= '0;
    end else begin
      state_q  <= state_d;
      result_q <= result_d;
      wr_q     <= wr_d;
      rw_q     <= rw_d;
      mcand_q  <= mcand_d;
      mplier_q <= mplier_d;
      acc_q    <= acc_d;
      cnt_q    <= cnt_d;
    end
  end

`ifdef EX_STAGE_FWD_EN
  // A result is complete on the edge it is written into result_q.
  assign complete = mul_done || (accept && (ALUctl != OP_MUL));

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      fwd_valid_q <= 1'b0;
      fwd_idx_q   <= '0;
      fwd_val_q   <= '0;
    end else if (complete && rw_d && (wr_d != 2'd0)) begin
      fwd_valid_q <= 1'b1;
      fwd_idx_q   <= wr_d;
      fwd_val_q   <= result_d;
    end
  end
`endif

  assign out_valid = (state_q == HOLD);
  assign Result    = result_q;
  assign Zero      = (result_q == '0);
  assign WR        = wr_q;
  assign RegWrite  = out_valid && rw_q;

endmodule
